// File: rtl/cpu_fetch_pkg.sv
// Shared constants and helpers for the moxie fetch/align stage.
// Holds the default reset vector, the form-1 long-opcode mask and width constants.
package cpu_fetch_pkg;

   localparam int HW_W   = 16;
   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_VECTOR_DEF = 32'h0000_1000;
   localparam logic [63:0]       LONG_MASK_DEF    = 64'h0;

   typedef struct packed {
      logic [HW_W-1:0]   opcode;
      logic [WORD_W-1:0] operand;
      logic [WORD_W-1:0] pc;
   } insn_t;

   // Form-1 opcodes (top bits 00) listed in the mask carry a 32-bit immediate.
   function automatic logic is_long(input logic [HW_W-1:0] h, input logic [63:0] mask);
      return (h[15:14] == 2'b00) && mask[h[13:8]];
   endfunction

endpackage

// File: rtl/cpu_fetch_hq.sv
// Halfword circular queue: push 1/2, pop 1/3, three-entry peek, synchronous clear.
// Storage is not reset; only the pointers and count are.
module cpu_fetch_hq
   import cpu_fetch_pkg::*;
#(
   parameter  int QDEPTH = 8,
   localparam int AW     = $clog2(QDEPTH),
   localparam int CW     = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic [1:0]      push_n,
   input  logic [HW_W-1:0] push_d0,
   input  logic [HW_W-1:0] push_d1,
   input  logic [1:0]      pop_n,
   output logic [HW_W-1:0] q0,
   output logic [HW_W-1:0] q1,
   output logic [HW_W-1:0] q2,
   output logic [CW-1:0]   count
);

   logic [QDEPTH-1:0][HW_W-1:0] mem;
   logic [AW-1:0]               head;
   logic [AW-1:0]               tail;

   // push_d0 is always the lower-address halfword of the pair.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) mem[tail] <= push_d0;
      if (push_n == 2'd2) mem[tail + AW'(1)] <= push_d1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + AW'(push_n);
         head  <= head + AW'(pop_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   assign q0 = mem[head];
   assign q1 = mem[head + AW'(1)];
   assign q2 = mem[head + AW'(2)];

endmodule

// File: rtl/cpu_fetch.sv
// Moxie instruction fetch and alignment: word reads into a halfword queue,
// 16-bit instruction assembly with optional 32-bit immediate, branch redirect.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int          QDEPTH       = 8,
   parameter logic [63:0] LONG_MASK    = LONG_MASK_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] imem_adr_o,
   output logic        imem_stb_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_dat_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        stall_i,
   output logic        valid_o,
   output logic [15:0] opcode_o,
   output logic [31:0] operand_o,
   output logic [31:0] pc_o
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic [HW_W-1:0] q0, q1, q2;
   logic [1:0]      push_n;
   logic [1:0]      pop_n;
   logic            head_long;
   logic            avail;
   logic            load;
   logic            take;
   logic            discard;
   logic            skip;
   logic            stb;
   logic            valid;
   logic [31:0]     adr;
   logic [31:0]     hpc;
   insn_t           outr;

   always_comb begin
      head_long = is_long(q0, LONG_MASK);
      avail     = head_long ? (cnt >= CW'(3)) : (cnt != '0);
      load      = (!valid || !stall_i) && avail;
      take      = stb && imem_ack_i && !discard && !branch_flag_i;
      push_n    = take ? (skip ? 2'd1 : 2'd2) : 2'd0;
      pop_n     = load ? (head_long ? 2'd3 : 2'd1) : 2'd0;
      cnt_next  = cnt + CW'(push_n) - CW'(pop_n);
   end

   cpu_fetch_hq #(.QDEPTH(QDEPTH)) u_hq (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     (branch_flag_i),
      .push_n  (push_n),
      .push_d0 (skip ? imem_dat_i[15:0] : imem_dat_i[31:16]),
      .push_d1 (imem_dat_i[15:0]),
      .pop_n   (pop_n),
      .q0      (q0),
      .q1      (q1),
      .q2      (q2),
      .count   (cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid   <= 1'b0;
         outr    <= '{opcode: '0, operand: '0, pc: RESET_VECTOR};
         hpc     <= RESET_VECTOR;
         stb     <= 1'b0;
         adr     <= {RESET_VECTOR[31:2], 2'b00};
         discard <= 1'b0;
         skip    <= RESET_VECTOR[1];
      end else if (branch_flag_i) begin
         // The bus moves to the target at once; a request still in flight
         // is kept alive and its data dropped when it finally completes.
         valid   <= 1'b0;
         outr.pc <= branch_target_i & ~32'h1;
         hpc     <= branch_target_i & ~32'h1;
         adr     <= {branch_target_i[31:2], 2'b00};
         stb     <= 1'b1;
         discard <= stb && !imem_ack_i;
         skip    <= branch_target_i[1];
      end else begin
         if (load) begin
            valid        <= 1'b1;
            outr.opcode  <= q0;
            outr.operand <= head_long ? {q1, q2} : 32'h0;
            outr.pc      <= hpc;
            hpc          <= hpc + (head_long ? 32'd6 : 32'd2);
         end else if (!valid || !stall_i) begin
            valid <= 1'b0;
         end
         // Re-request only with room for a full word after this cycle's pop/push.
         if (stb && imem_ack_i) begin
            if (discard) begin
               discard <= 1'b0;
            end else begin
               adr  <= adr + 32'd4;
               skip <= 1'b0;
            end
            stb <= (cnt_next <= CW'(QDEPTH - 2));
         end else if (!stb) begin
            stb <= (cnt_next <= CW'(QDEPTH - 2));
         end
      end
   end

   assign imem_adr_o = adr;
   assign imem_stb_o = stb;
   assign valid_o    = valid;
   assign opcode_o   = outr.opcode;
   assign operand_o  = outr.operand;
   assign pc_o       = outr.pc;

endmodule
